// File: rtl/cache_mem_pkg.sv
// Shared types and default widths for the I-cache/D-cache backing-memory arbiter.
package cache_mem_pkg;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_LINE_W      = 128;
    localparam int DEF_WDATA_W     = 32;
    localparam int DEF_TIMEOUT_CYC = 64;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker: on a tie the requester that did not
// own the memory last time wins.
module rr_arb2
    import cache_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_owner,
    output logic       gnt_valid,
    output owner_e     winner
);

    // req[0] is the I-cache, req[1] the D-cache
    always_comb begin
        gnt_valid = |req;
        winner    = OWN_IC;
        case (req)
            2'b01:   winner = OWN_IC;
            2'b10:   winner = OWN_DC;
            2'b11:   winner = (last_owner == OWN_IC) ? OWN_DC : OWN_IC;
            default: winner = OWN_IC;
        endcase
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single line memory between I-cache refills and D-cache
// reads/writes, with a watchdog that ends a hung access with a sticky error.
module cache_mem_arbiter
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LINE_W      = DEF_LINE_W,
    parameter int WDATA_W     = DEF_WDATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ic_req_i,
    input  logic [ADDR_W-1:0]  ic_addr_i,
    output logic               ic_gnt_o,
    output logic               ic_comp_o,
    output logic [LINE_W-1:0]  ic_data_o,
    input  logic               dc_r_req_i,
    input  logic               dc_w_req_i,
    input  logic [ADDR_W-1:0]  dc_addr_i,
    input  logic [1:0]         dc_blockoffset_i,
    input  logic [WDATA_W-1:0] dc_wr_data_i,
    output logic               dc_gnt_o,
    output logic               dc_comp_o,
    output logic [LINE_W-1:0]  dc_data_o,
    output logic               mem_r_req_o,
    output logic               mem_w_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [1:0]         mem_blockoffset_o,
    output logic [WDATA_W-1:0] mem_wr_data_o,
    input  logic               mem_comp_i,
    input  logic [LINE_W-1:0]  mem_data_i,
    output logic               timeout_err_o
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    arb_state_e         state_q, state_d;
    owner_e             owner_q, owner_d;
    owner_e             last_owner_q, last_owner_d;
    mem_op_e            op_q, op_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [1:0]         off_q, off_d;
    logic [WDATA_W-1:0] wdata_q, wdata_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               timeout_q, timeout_d;
    logic [LINE_W-1:0]  ic_data_q, ic_data_d;
    logic [LINE_W-1:0]  dc_data_q, dc_data_d;
    logic               ic_comp_q, ic_comp_d;
    logic               dc_comp_q, dc_comp_d;
    logic               ic_gnt_q, ic_gnt_d;
    logic               dc_gnt_q, dc_gnt_d;
    logic               mem_r_q, mem_r_d;
    logic               mem_w_q, mem_w_d;

    logic [1:0]         req_s;
    logic               gnt_valid_s;
    owner_e             winner_s;

    assign req_s = {dc_r_req_i | dc_w_req_i, ic_req_i};

    rr_arb2 u_rr_arb2 (
        .req        (req_s),
        .last_owner (last_owner_q),
        .gnt_valid  (gnt_valid_s),
        .winner     (winner_s)
    );

    // Next state, command latch and watchdog; handshake outputs follow the next state
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        op_d         = op_q;
        addr_d       = addr_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        wdog_d       = wdog_q;
        timeout_d    = timeout_q;
        ic_data_d    = ic_data_q;
        dc_data_d    = dc_data_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    state_d = ST_WAIT;
                    owner_d = winner_s;
                    if (winner_s == OWN_DC) begin
                        addr_d  = dc_addr_i;
                        off_d   = dc_blockoffset_i;
                        wdata_d = dc_wr_data_i;
                        op_d    = dc_w_req_i ? OP_WR : OP_RD;
                    end else begin
                        addr_d  = ic_addr_i;
                        off_d   = 2'b00;
                        wdata_d = '0;
                        op_d    = OP_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A completion arriving on the expiry cycle wins over the timeout
                if (mem_comp_i || (wdog_q == WD_LAST)) begin
                    state_d      = ST_DONE;
                    wdog_d       = '0;
                    last_owner_d = owner_q;
                    timeout_d    = timeout_q | ~mem_comp_i;
                    if (owner_q == OWN_IC) begin
                        ic_data_d = mem_comp_i ? mem_data_i : '0;
                    end else begin
                        dc_data_d = mem_comp_i ? mem_data_i : '0;
                    end
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        mem_r_d   = (state_d == ST_WAIT) && (op_d == OP_RD);
        mem_w_d   = (state_d == ST_WAIT) && (op_d == OP_WR);
        ic_gnt_d  = (state_d == ST_WAIT) && (owner_d == OWN_IC);
        dc_gnt_d  = (state_d == ST_WAIT) && (owner_d == OWN_DC);
        ic_comp_d = (state_d == ST_DONE) && (owner_d == OWN_IC);
        dc_comp_d = (state_d == ST_DONE) && (owner_d == OWN_DC);
    end

    // State and output registers; reset drops every request and grant at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IC;
            last_owner_q <= OWN_IC;
            op_q         <= OP_RD;
            addr_q       <= '0;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            wdog_q       <= '0;
            timeout_q    <= 1'b0;
            ic_data_q    <= '0;
            dc_data_q    <= '0;
            ic_comp_q    <= 1'b0;
            dc_comp_q    <= 1'b0;
            ic_gnt_q     <= 1'b0;
            dc_gnt_q     <= 1'b0;
            mem_r_q      <= 1'b0;
            mem_w_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            wdog_q       <= wdog_d;
            timeout_q    <= timeout_d;
            ic_data_q    <= ic_data_d;
            dc_data_q    <= dc_data_d;
            ic_comp_q    <= ic_comp_d;
            dc_comp_q    <= dc_comp_d;
            ic_gnt_q     <= ic_gnt_d;
            dc_gnt_q     <= dc_gnt_d;
            mem_r_q      <= mem_r_d;
            mem_w_q      <= mem_w_d;
        end
    end

    assign ic_gnt_o          = ic_gnt_q;
    assign ic_comp_o         = ic_comp_q;
    assign ic_data_o         = ic_data_q;
    assign dc_gnt_o          = dc_gnt_q;
    assign dc_comp_o         = dc_comp_q;
    assign dc_data_o         = dc_data_q;
    assign mem_r_req_o       = mem_r_q;
    assign mem_w_req_o       = mem_w_q;
    assign mem_addr_o        = addr_q;
    assign mem_blockoffset_o = off_q;
    assign mem_wr_data_o     = wdata_q;
    assign timeout_err_o     = timeout_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed and randomized bench for cache_mem_arbiter, checked against a
// transaction-level model of ownership, latched commands, returned lines and timeouts.
module tb_cache_mem_arbiter;

    localparam int TO = 64;

    logic         clk;
    logic         reset_n;
    logic         ic_req_i;
    logic [7:0]   ic_addr_i;
    logic         ic_gnt_o;
    logic         ic_comp_o;
    logic [127:0] ic_data_o;
    logic         dc_r_req_i;
    logic         dc_w_req_i;
    logic [7:0]   dc_addr_i;
    logic [1:0]   dc_blockoffset_i;
    logic [31:0]  dc_wr_data_i;
    logic         dc_gnt_o;
    logic         dc_comp_o;
    logic [127:0] dc_data_o;
    logic         mem_r_req_o;
    logic         mem_w_req_o;
    logic [7:0]   mem_addr_o;
    logic [1:0]   mem_blockoffset_o;
    logic [31:0]  mem_wr_data_o;
    logic         mem_comp_i;
    logic [127:0] mem_data_i;
    logic         timeout_err_o;

    int           n_cmp;
    int           n_err;
    bit           last_dc_m;
    bit           timeout_m;
    logic [127:0] ic_data_m;
    logic [127:0] dc_data_m;

    cache_mem_arbiter #(
        .ADDR_W      (8),
        .LINE_W      (128),
        .WDATA_W     (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ic_req_i          (ic_req_i),
        .ic_addr_i         (ic_addr_i),
        .ic_gnt_o          (ic_gnt_o),
        .ic_comp_o         (ic_comp_o),
        .ic_data_o         (ic_data_o),
        .dc_r_req_i        (dc_r_req_i),
        .dc_w_req_i        (dc_w_req_i),
        .dc_addr_i         (dc_addr_i),
        .dc_blockoffset_i  (dc_blockoffset_i),
        .dc_wr_data_i      (dc_wr_data_i),
        .dc_gnt_o          (dc_gnt_o),
        .dc_comp_o         (dc_comp_o),
        .dc_data_o         (dc_data_o),
        .mem_r_req_o       (mem_r_req_o),
        .mem_w_req_o       (mem_w_req_o),
        .mem_addr_o        (mem_addr_o),
        .mem_blockoffset_o (mem_blockoffset_o),
        .mem_wr_data_o     (mem_wr_data_o),
        .mem_comp_i        (mem_comp_i),
        .mem_data_i        (mem_data_i),
        .timeout_err_o     (timeout_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk_idle(input string tag);
        chkb({tag, "_ic_gnt"}, ic_gnt_o, 1'b0);
        chkb({tag, "_dc_gnt"}, dc_gnt_o, 1'b0);
        chkb({tag, "_mem_r"}, mem_r_req_o, 1'b0);
        chkb({tag, "_mem_w"}, mem_w_req_o, 1'b0);
        chkb({tag, "_ic_comp"}, ic_comp_o, 1'b0);
        chkb({tag, "_dc_comp"}, dc_comp_o, 1'b0);
        chkb({tag, "_timeout"}, timeout_err_o, timeout_m);
        chk({tag, "_ic_data"}, ic_data_o, ic_data_m);
        chk({tag, "_dc_data"}, dc_data_o, dc_data_m);
    endtask

    function automatic bit pending();
        return ic_req_i || dc_r_req_i || dc_w_req_i;
    endfunction

    task automatic model_reset();
        last_dc_m = 1'b0;
        timeout_m = 1'b0;
        ic_data_m = '0;
        dc_data_m = '0;
    endtask

    // Called in an IDLE cycle with requests already driven; ends in the IDLE cycle after DONE.
    task automatic do_txn(input string tag, input int lat, input bit send_comp,
                          input bit wiggle, input bit raise_other, input logic [127:0] rdata);
        bit ic_act, dc_act, dc_own, wr;
        logic [7:0]  ea;
        logic [1:0]  eo;
        logic [31:0] ew;
        ic_act = ic_req_i;
        dc_act = dc_r_req_i | dc_w_req_i;
        dc_own = dc_act && (!ic_act || !last_dc_m);
        wr     = dc_own && dc_w_req_i;
        ea     = dc_own ? dc_addr_i : ic_addr_i;
        eo     = dc_blockoffset_i;
        ew     = dc_wr_data_i;
        for (int j = 1; j <= lat; j++) begin
            tick();
            mem_comp_i = 1'b0;
            chkb({tag, "_ic_gnt"}, ic_gnt_o, !dc_own);
            chkb({tag, "_dc_gnt"}, dc_gnt_o, dc_own);
            chkb({tag, "_mem_r"}, mem_r_req_o, !wr);
            chkb({tag, "_mem_w"}, mem_w_req_o, wr);
            chk({tag, "_addr"}, 128'(mem_addr_o), 128'(ea));
            if (dc_own) begin
                chk({tag, "_off"}, 128'(mem_blockoffset_o), 128'(eo));
                chk({tag, "_wdata"}, 128'(mem_wr_data_o), 128'(ew));
            end
            chkb({tag, "_ic_comp_w"}, ic_comp_o, 1'b0);
            chkb({tag, "_dc_comp_w"}, dc_comp_o, 1'b0);
            chkb({tag, "_timeout_w"}, timeout_err_o, timeout_m);
            if (wiggle) begin
                ic_addr_i        = 8'($urandom);
                dc_addr_i        = 8'($urandom);
                dc_blockoffset_i = 2'($urandom);
                dc_wr_data_i     = $urandom;
            end
            if (raise_other && dc_own && !ic_req_i) ic_req_i = 1'($urandom);
            if (raise_other && !dc_own && !dc_r_req_i && !dc_w_req_i) dc_r_req_i = 1'($urandom);
            mem_data_i = rnd128();
            if (j == lat && send_comp) begin
                mem_comp_i = 1'b1;
                mem_data_i = rdata;
            end
        end
        tick();
        mem_comp_i = 1'b0;
        mem_data_i = rnd128();
        if (!send_comp) timeout_m = 1'b1;
        if (dc_own) dc_data_m = send_comp ? rdata : '0;
        else        ic_data_m = send_comp ? rdata : '0;
        last_dc_m = dc_own;
        chkb({tag, "_ic_comp"}, ic_comp_o, !dc_own);
        chkb({tag, "_dc_comp"}, dc_comp_o, dc_own);
        chkb({tag, "_done_ic_gnt"}, ic_gnt_o, 1'b0);
        chkb({tag, "_done_dc_gnt"}, dc_gnt_o, 1'b0);
        chkb({tag, "_done_mem_r"}, mem_r_req_o, 1'b0);
        chkb({tag, "_done_mem_w"}, mem_w_req_o, 1'b0);
        chkb({tag, "_done_timeout"}, timeout_err_o, timeout_m);
        chk({tag, "_ic_data"}, ic_data_o, ic_data_m);
        chk({tag, "_dc_data"}, dc_data_o, dc_data_m);
        if (dc_own) begin
            dc_r_req_i = 1'b0;
            dc_w_req_i = 1'b0;
        end else begin
            ic_req_i = 1'b0;
        end
        tick();
        chk_idle({tag, "_post"});
    endtask

    initial begin
        int m;
        n_cmp = 0;
        n_err = 0;
        model_reset();
        reset_n          = 1'b0;
        ic_req_i         = 1'b0;
        ic_addr_i        = 8'h00;
        dc_r_req_i       = 1'b0;
        dc_w_req_i       = 1'b0;
        dc_addr_i        = 8'h00;
        dc_blockoffset_i = 2'b00;
        dc_wr_data_i     = 32'h0;
        mem_comp_i       = 1'b0;
        mem_data_i       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset_addr", 128'(mem_addr_o), 128'h0);
        chk("reset_off", 128'(mem_blockoffset_o), 128'h0);
        chk("reset_wdata", 128'(mem_wr_data_o), 128'h0);
        reset_n = 1'b1;
        tick();

        // I-cache refill, completion in the third WAIT cycle
        ic_req_i  = 1'b1;
        ic_addr_i = 8'h12;
        do_txn("ic_read", 3, 1'b1, 1'b0, 1'b0, {16{8'hA5}});

        // Continuous requests from both: DC, IC, DC, IC
        ic_req_i   = 1'b1;
        dc_r_req_i = 1'b1;
        dc_addr_i  = 8'h21;
        for (int k = 0; k < 4; k++) begin
            do_txn("alt", 1 + k, 1'b1, 1'b0, 1'b0, rnd128());
            if (k < 2) begin
                ic_req_i   = 1'b1;
                dc_r_req_i = 1'b1;
            end
        end

        // Store with address/data disturbed during WAIT
        tick();
        dc_w_req_i       = 1'b1;
        dc_addr_i        = 8'h40;
        dc_blockoffset_i = 2'd2;
        dc_wr_data_i     = 32'hDEADBEEF;
        do_txn("dc_write", 4, 1'b1, 1'b1, 1'b0, rnd128());

        // Read and write together: write wins
        tick();
        dc_r_req_i = 1'b1;
        dc_w_req_i = 1'b1;
        dc_addr_i  = 8'h33;
        do_txn("dc_rw", 2, 1'b1, 1'b0, 1'b0, rnd128());

        // Completion on the watchdog expiry cycle is a normal completion
        tick();
        ic_req_i  = 1'b1;
        ic_addr_i = 8'h77;
        do_txn("expiry_comp", TO, 1'b1, 1'b0, 1'b0, rnd128());

        // Hung memory: timeout after TO WAIT cycles
        tick();
        dc_r_req_i = 1'b1;
        dc_addr_i  = 8'h5C;
        do_txn("timeout", TO, 1'b0, 1'b0, 1'b0, '0);

        // Randomized traffic; timeout flag must stay sticky
        for (int it = 0; it < 40; it++) begin
            if (!pending()) begin
                tick();
                chk_idle("rnd_idle");
            end
            if (!ic_req_i && ($urandom % 2 == 0)) begin
                ic_req_i  = 1'b1;
                ic_addr_i = 8'($urandom);
            end
            if (!dc_r_req_i && !dc_w_req_i && ($urandom % 2 == 0)) begin
                m                = $urandom_range(1, 3);
                dc_r_req_i       = m[0];
                dc_w_req_i       = m[1];
                dc_addr_i        = 8'($urandom);
                dc_blockoffset_i = 2'($urandom);
                dc_wr_data_i     = $urandom;
            end
            if (!pending()) begin
                ic_req_i  = 1'b1;
                ic_addr_i = 8'($urandom);
            end
            do_txn("rnd", $urandom_range(1, 5), 1'b1, 1'($urandom), 1'b1, rnd128());
        end
        for (int d = 0; d < 2; d++) begin
            if (pending()) do_txn("drain", 1, 1'b1, 1'b0, 1'b0, rnd128());
        end

        // Reset in the middle of WAIT, then a stray completion
        tick();
        ic_req_i  = 1'b1;
        ic_addr_i = 8'h99;
        tick();
        tick();
        chkb("pre_reset_mem_r", mem_r_req_o, 1'b1);
        chkb("pre_reset_ic_gnt", ic_gnt_o, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_idle("mid_reset");
        chk("mid_reset_addr", 128'(mem_addr_o), 128'h0);
        ic_req_i = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();
        mem_comp_i = 1'b1;
        mem_data_i = rnd128();
        tick();
        mem_comp_i = 1'b0;
        chk_idle("stray_comp");
        tick();
        chk_idle("stray_after");

        // Tie priority back to the D-cache after reset
        ic_req_i   = 1'b1;
        ic_addr_i  = 8'h0A;
        dc_r_req_i = 1'b1;
        dc_addr_i  = 8'h0B;
        do_txn("post_reset_dc", 2, 1'b1, 1'b0, 1'b0, rnd128());
        do_txn("post_reset_ic", 1, 1'b1, 1'b0, 1'b0, rnd128());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
